layer_sequencer: RTL

Frame-level controller that runs the inference pipeline's layer engines (conv, pool, dense, argmax, ...) strictly in order using each engine's start/done handshake. Accepts one frame request, pulses each stage's start, and waits for that stage's done. Toggles the ping-pong activation-buffer select between stages. Guards every stage with a watchdog timeout and reports one frame-done pulse. Sits between the top-level frame source and the layer engines.

---
 rtl/layer_sequencer_if.sv | 49 ++++
 rtl/layer_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer_if.sv
// Frame and engine handshake bundle for layer_sequencer.
// master: the sequencer itself; slave: frame source plus layer engines.
interface layer_sequencer_if #(
    parameter int NUM_STAGES = 4,
    parameter int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
);
    logic                  frame_valid;
    logic                  frame_ready;
    logic                  abort;
    logic                  clear_err;
    logic [NUM_STAGES-1:0] stage_start;
    logic [NUM_STAGES-1:0] stage_done;
    logic                  buf_sel;
    logic                  busy;
    logic                  frame_done;
    logic                  timeout_err;
    logic [IDX_W-1:0]      err_stage;
    logic [31:0]           cycles_last;

    modport master (
        input  frame_valid,
        input  abort,
        input  clear_err,
        input  stage_done,
        output frame_ready,
        output stage_start,
        output buf_sel,
        output busy,
        output frame_done,
        output timeout_err,
        output err_stage,
        output cycles_last
    );

    modport slave (
        output frame_valid,
        output abort,
        output clear_err,
        output stage_done,
        input  frame_ready,
        input  stage_start,
        input  buf_sel,
        input  busy,
        input  frame_done,
        input  timeout_err,
        input  err_stage,
        input  cycles_last
    );
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs NUM_STAGES layer engines strictly in order for one
// frame, toggling the ping-pong activation buffer between stages and guarding
// each stage with a watchdog.
// Optional frame-latency counter: define SEQ_PERF_CNT_EN to build it; when
// undefined, cycles_last is tied to 0.
module layer_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int IDX_W          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    layer_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FINISH,
        S_ERROR
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam bit               WD_EN    = (TIMEOUT_CYCLES != 0);
    // The watchdog counts already-elapsed WAIT cycles, so the last allowed
    // WAIT cycle is the one where the count equals TIMEOUT_CYCLES-1.
    localparam logic [31:0]      WD_LAST  = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  buf_sel_q, buf_sel_d;
    logic [31:0]           wd_q, wd_d;
    logic [IDX_W-1:0]      err_stage_q, err_stage_d;
    logic [NUM_STAGES-1:0] stage_sel;
    logic                  done_sel;

    // One-hot decode of the active stage index.
    always_comb begin
        stage_sel = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_sel[i] = (idx_q == IDX_W'(i));
        end
    end

    // Only the active engine's done bit matters; strays from others are masked.
    assign done_sel = |(bus.stage_done & stage_sel);

    // Next-state logic; abort outranks done, which outranks the watchdog.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        buf_sel_d   = buf_sel_q;
        wd_d        = wd_q;
        err_stage_d = err_stage_q;
        case (state_q)
            S_IDLE: begin
                if (bus.frame_valid) begin
                    idx_d     = '0;
                    buf_sel_d = 1'b0;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (bus.abort) begin
                    idx_d     = '0;
                    buf_sel_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    wd_d    = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.abort) begin
                    idx_d     = '0;
                    buf_sel_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (done_sel) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        buf_sel_d = ~buf_sel_q;
                        state_d   = S_LAUNCH;
                    end
                end else if (WD_EN) begin
                    if (wd_q == WD_LAST) begin
                        err_stage_d = idx_q;
                        state_d     = S_ERROR;
                    end else begin
                        wd_d = wd_q + 32'd1;
                    end
                end
            end
            S_FINISH: begin
                if (bus.abort) begin
                    idx_d     = '0;
                    buf_sel_d = 1'b0;
                end
                state_d = S_IDLE;
            end
            S_ERROR: begin
                if (bus.clear_err) begin
                    buf_sel_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            buf_sel_q   <= 1'b0;
            wd_q        <= '0;
            err_stage_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            buf_sel_q   <= buf_sel_d;
            wd_q        <= wd_d;
            err_stage_q <= err_stage_d;
        end
    end

    assign bus.frame_ready = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.frame_done  = (state_q == S_FINISH);
    assign bus.timeout_err = (state_q == S_ERROR);
    assign bus.stage_start = (state_q == S_LAUNCH) ? stage_sel : '0;
    assign bus.buf_sel     = buf_sel_q;
    assign bus.err_stage   = err_stage_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cycles_last_q, cycles_last_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Latency counter: zeroed on acceptance, runs while busy. cnt_q lags the
    // elapsed cycle count by one, hence the increment when latching.
    always_comb begin
        cnt_d         = cnt_q;
        cycles_last_d = cycles_last_q;
        if (state_q == S_IDLE) begin
            if (bus.frame_valid) begin
                cnt_d = '0;
            end
        end else begin
            cnt_d = sat_inc(cnt_q);
        end
        if (state_q == S_FINISH && !bus.abort) begin
            cycles_last_d = sat_inc(cnt_q);
        end
    end

    // Latency counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            cycles_last_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            cycles_last_q <= cycles_last_d;
        end
    end

    assign bus.cycles_last = cycles_last_q;
`else
    assign bus.cycles_last = '0;
`endif

endmodule
